// File: rtl/layer_boundary_skid_reg.sv
// Elastic two-entry pipeline register between the layer-0 and layer-1 neuron
// LUT arrays of one ensemble. A main register drives the layer-1 fan-in and
// a skid register absorbs the one extra vector that can arrive while the
// downstream stalls. s_ready is registered, so there is no combinational
// path from m_ready to s_ready or from s_valid to m_valid. A wrapping counter
// tracks completed output transfers for throughput checks.
module layer_boundary_skid_reg #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] sample_count
);

  logic             m_valid_q,    m_valid_d;
  logic [WIDTH-1:0] m_data_q,     m_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             s_ready_q,    s_ready_d;
  logic [CNT_W-1:0] count_q,      count_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = s_valid & s_ready_q;
  assign out_xfer = m_valid_q & m_ready;

  // Next-state for main/skid entries, ready and the sample counter.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    count_d      = count_q;

    if (!m_valid_q || out_xfer) begin
      // Main is free this edge: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        skid_valid_d = 1'b0;
        if (in_xfer) begin
          skid_data_d  = s_data;
          skid_valid_d = 1'b1;
        end
      end else if (in_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Main is stalled: park the new vector in the skid entry.
      skid_data_d  = s_data;
      skid_valid_d = 1'b1;
    end

    // Flush empties both entries; data payloads are left as don't-care.
    if (flush) begin
      m_valid_d    = 1'b0;
      skid_valid_d = 1'b0;
    end

    // A transfer completing in the flush cycle still counts as delivered.
    if (out_xfer) begin
      count_d = count_q + 1'b1;
    end

    s_ready_d = ~skid_valid_d;
  end

  // State registers with asynchronous clear of every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      // NOTE: the data payloads are reset as well as the valid bits, so the
      // layer-1 inputs see a defined all-zero vector straight out of reset.
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values computed before the edge.
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
      count_q      <= count_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign sample_count = count_q;

endmodule
